// File: rtl/pet_stats.sv
// Pet vitals and action timer: times EAT/SLEEP/GAME actions from the navigation FSM,
// boosts the matching vital, decays all vitals over time and reports done/game-over.
module pet_stats #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int ACTION_TICKS = 3,
    parameter int DECAY_TICKS  = 10,
    parameter int STAT_MAX     = 100,
    parameter int BOOST        = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] location,
    input  logic [3:0] action,
    input  logic       transition,
    output logic       doneAction,
    output logic       gameEnd,
    output logic [6:0] fullness,
    output logic [6:0] energy,
    output logic [6:0] fun
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int AW = $clog2(ACTION_TICKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_WAIT, S_DEAD} state_t;
    typedef enum logic [1:0] {T_FULL, T_ENERGY, T_FUN, T_NONE} target_t;

    state_t          state_q, state_d;
    target_t         tgt_q, tgt_d, req;
    logic [AW-1:0]   act_cnt_q, act_cnt_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]   decay_cnt_q, decay_cnt_d;
    logic [2:0][6:0] vital_q, vital_d;
    logic            done_q, done_d;
    logic            dead_q, dead_d;
    logic            active, tick, decay, boost_en;
    int              sum;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        req = T_NONE;
        if (!transition) begin
            if (location == 4'd1 && action == 4'd1)      req = T_FULL;
            else if (location == 4'd1 && action == 4'd2) req = T_ENERGY;
            else if (location == 4'd3 && action == 4'd3) req = T_FUN;
        end
        active = (req != T_NONE);
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        act_cnt_d   = act_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        decay_cnt_d = decay_cnt_q;
        vital_d     = vital_q;
        boost_en    = 1'b0;
        sum         = 0;

        // Timebase freezes in DEAD, so a held tick count cannot keep firing ticks.
        tick  = (state_q != S_DEAD) && (tick_cnt_q == TW'(TICK_DIV - 1));
        decay = tick && (decay_cnt_q == DW'(DECAY_TICKS - 1));
        if (state_q != S_DEAD) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (tick) decay_cnt_d = decay ? '0 : decay_cnt_q + DW'(1);

        if (vital_q[0] == 7'd0 || vital_q[1] == 7'd0 || vital_q[2] == 7'd0) begin
            state_d = S_DEAD;
        end else begin
            case (state_q)
                S_IDLE: if (active) begin
                    tgt_d     = req;
                    act_cnt_d = AW'(ACTION_TICKS);
                    state_d   = S_RUN;
                end
                S_RUN: if (!active || req != tgt_q) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    boost_en  = 1'b1;
                    act_cnt_d = act_cnt_q - AW'(1);
                    if (act_cnt_q == AW'(1)) state_d = S_DONE;
                end
                S_DONE:  state_d = S_WAIT;
                S_WAIT:  if (!active) state_d = S_IDLE;
                default: state_d = S_DEAD;
            endcase
        end

        // Boost and decay combine before clamping, so a same-tick hit nets BOOST-1.
        for (int i = 0; i < 3; i++) begin
            sum = int'(vital_q[i]) + ((boost_en && tgt_q == target_t'(i)) ? BOOST : 0)
                  - (decay ? 1 : 0);
            if (sum < 0)              vital_d[i] = 7'd0;
            else if (sum > STAT_MAX)  vital_d[i] = 7'(STAT_MAX);
            else                      vital_d[i] = 7'(sum);
        end

        done_d = (state_d == S_DONE);
        dead_d = (state_d == S_DEAD);
    end

    // NOTE: sequential state uses non-blocking assignments only; the vital bank is a
    // handful of flops, so it is reset like any other register rather than left undefined.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            tgt_q       <= T_FULL;
            act_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            decay_cnt_q <= '0;
            vital_q     <= {3{7'(STAT_MAX)}};
            done_q      <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            act_cnt_q   <= act_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            decay_cnt_q <= decay_cnt_d;
            vital_q     <= vital_d;
            done_q      <= done_d;
            dead_q      <= dead_d;
        end
    end

    assign fullness   = vital_q[0];
    assign energy     = vital_q[1];
    assign fun        = vital_q[2];
    assign doneAction = done_q;
    assign gameEnd    = dead_q;

endmodule

// File: tb/tb_pet_stats.sv
// Randomized scoreboard bench for pet_stats: a cycle-level reference model predicts
// each done pulse and the vitals, a monitor pops predictions when the DUT pulses.
module tb_pet_stats;

    localparam int TICK_DIV = 4, ACTION_TICKS = 3, DECAY_TICKS = 8, BOOST = 2;

    typedef enum int {M_IDLE, M_RUN, M_DONE, M_WAIT, M_DEAD} mphase_t;
    typedef struct packed {
        mphase_t ph;
        int tcnt; int dcnt; int acnt; int tgt;
        int v0; int v1; int v2;
    } model_t;

    logic       clk, resetn;
    logic [3:0] loc, act, s_loc, s_act;
    logic       tr, s_tr;
    logic       doneAction, gameEnd, s_doneAction, s_gameEnd;
    logic [6:0] fullness, energy, fun, s_fullness, s_energy, s_fun;

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, s_done_cnt = 0;
    int q_main[$], q_starve[$];
    model_t mm, ms;

    pet_stats #(.TICK_DIV(TICK_DIV), .ACTION_TICKS(ACTION_TICKS), .DECAY_TICKS(DECAY_TICKS),
                .STAT_MAX(100), .BOOST(BOOST)) u_main (
        .clk(clk), .resetn(resetn), .location(loc), .action(act), .transition(tr),
        .doneAction(doneAction), .gameEnd(gameEnd),
        .fullness(fullness), .energy(energy), .fun(fun));

    pet_stats #(.TICK_DIV(TICK_DIV), .ACTION_TICKS(ACTION_TICKS), .DECAY_TICKS(DECAY_TICKS),
                .STAT_MAX(3), .BOOST(BOOST)) u_starve (
        .clk(clk), .resetn(resetn), .location(s_loc), .action(s_act), .transition(s_tr),
        .doneAction(s_doneAction), .gameEnd(s_gameEnd),
        .fullness(s_fullness), .energy(s_energy), .fun(s_fun));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int smax);
        return (v < 0) ? 0 : ((v > smax) ? smax : v);
    endfunction

    function automatic int pack_vit(input model_t m);
        return (m.v0 << 14) | (m.v1 << 7) | m.v2;
    endfunction

    function automatic model_t model_reset(input int smax);
        model_t m;
        m = '{ph: M_IDLE, tcnt: 0, dcnt: 0, acnt: 0, tgt: 0, v0: smax, v1: smax, v2: smax};
        return m;
    endfunction

    // One clock of the pet rules, written from the behavioural description.
    function automatic model_t step(input model_t m, input logic [3:0] l, input logic [3:0] a,
                                    input logic t, input int smax);
        model_t n;
        int req, add0, add1, add2;
        bit tick, dec;
        n = m; req = -1; add0 = 0; add1 = 0; add2 = 0;
        if (m.ph == M_DEAD) return m;
        if (!t && l == 1 && a == 1)      req = 0;
        else if (!t && l == 1 && a == 2) req = 1;
        else if (!t && l == 3 && a == 3) req = 2;
        tick = (m.tcnt == TICK_DIV - 1);
        dec  = tick && (m.dcnt == DECAY_TICKS - 1);
        n.tcnt = (m.tcnt + 1) % TICK_DIV;
        if (tick) n.dcnt = (m.dcnt + 1) % DECAY_TICKS;
        if (m.v0 == 0 || m.v1 == 0 || m.v2 == 0) n.ph = M_DEAD;
        else case (m.ph)
            M_IDLE: if (req >= 0) begin n.ph = M_RUN; n.tgt = req; n.acnt = ACTION_TICKS; end
            M_RUN: if (req != m.tgt) n.ph = M_IDLE;
                   else if (tick) begin
                       n.acnt = m.acnt - 1;
                       if (m.tgt == 0) add0 = BOOST;
                       if (m.tgt == 1) add1 = BOOST;
                       if (m.tgt == 2) add2 = BOOST;
                       if (n.acnt == 0) n.ph = M_DONE;
                   end
            M_DONE: n.ph = M_WAIT;
            M_WAIT: if (req < 0) n.ph = M_IDLE;
            default: ;
        endcase
        n.v0 = clamp(m.v0 + add0 - int'(dec), smax);
        n.v1 = clamp(m.v1 + add1 - int'(dec), smax);
        n.v2 = clamp(m.v2 + add2 - int'(dec), smax);
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mm = model_reset(100);
            ms = model_reset(3);
        end else begin
            mm = step(mm, loc, act, tr, 100);
            ms = step(ms, s_loc, s_act, s_tr, 3);
            if (mm.ph == M_DONE) q_main.push_back(pack_vit(mm));
            if (ms.ph == M_DONE) q_starve.push_back(pack_vit(ms));
        end
    end

    always @(negedge clk) begin
        if (resetn && doneAction) begin
            done_cnt++;
            if (q_main.size() == 0) check("main_unexpected_done", 1, 0);
            else check("main_done_vitals", int'({fullness, energy, fun}), q_main.pop_front());
        end
        if (resetn && s_doneAction) begin
            s_done_cnt++;
            if (q_starve.size() == 0) check("starve_unexpected_done", 1, 0);
            else check("starve_done_vitals", int'({s_fullness, s_energy, s_fun}), q_starve.pop_front());
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic check_main(input string tag);
        check({tag, "_fullness"}, int'(fullness), mm.v0);
        check({tag, "_energy"}, int'(energy), mm.v1);
        check({tag, "_fun"}, int'(fun), mm.v2);
        check({tag, "_done"}, int'(doneAction), int'(mm.ph == M_DONE));
        check({tag, "_gameend"}, int'(gameEnd), int'(mm.ph == M_DEAD));
    endtask

    task automatic check_starve(input string tag);
        check({tag, "_s_vitals"}, int'({s_fullness, s_energy, s_fun}), pack_vit(ms));
        check({tag, "_s_gameend"}, int'(s_gameEnd), int'(ms.ph == M_DEAD));
    endtask

    task automatic wait_done(input string tag);
        int c;
        bit seen;
        c = 0; seen = 0;
        while (!seen && c < 40) begin
            sync();
            c++;
            if (doneAction) seen = 1;
        end
        check({tag, "_pulse_seen"}, int'(seen), 1);
        check({tag, "_latency_in_9_12"}, int'(c - 1 >= 9 && c - 1 <= 12), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] tl [6];
        logic [3:0] ta [6];
        logic       tt [6];
        int d0, e0, k;

        resetn = 1'b0;
        loc = 0; act = 0; tr = 0;
        s_loc = 0; s_act = 0; s_tr = 0;
        repeat (3) sync();
        resetn = 1'b1;
        check("rst_fullness", int'(fullness), 100);
        check("rst_energy", int'(energy), 100);
        check("rst_fun", int'(fun), 100);
        check("rst_done", int'(doneAction), 0);
        check("rst_gameend", int'(gameEnd), 0);

        // Idle: main decays 5 times; the STAT_MAX=3 copy starves at edge 96.
        for (int i = 1; i <= 160; i++) begin
            sync();
            if (i == 96) begin
                check("starve_vitals_zero", int'({s_fullness, s_energy, s_fun}), 0);
                check("starve_gameend_not_yet", int'(s_gameEnd), 0);
            end
            if (i == 97) check("starve_gameend_next", int'(s_gameEnd), 1);
        end
        check("idle_fullness", int'(fullness), 95);
        check("idle_energy", int'(energy), 95);
        check("idle_fun", int'(fun), 95);
        check_main("idle");
        check("starve_gameend_held", int'(s_gameEnd), 1);

        loc = 1; act = 1; tr = 0;
        wait_done("eat1");
        check("eat_fullness_clamped", int'(fullness), 100);
        check("eat_energy", int'(energy), 95);
        check("eat_fun", int'(fun), 95);
        check_main("eat1");
        d0 = done_cnt;
        repeat (50) sync();
        check("eat_hold_no_repulse", done_cnt, d0);
        tr = 1; sync(); tr = 0;
        wait_done("eat2");
        check("eat2_one_more_pulse", done_cnt, d0 + 1);
        check_main("eat2");

        s_loc = 3; s_act = 3;
        repeat (20) sync();
        check("dead_game_no_pulse", s_done_cnt, 0);
        check("dead_vitals_frozen", int'({s_fullness, s_energy, s_fun}), 0);
        check_starve("dead_game");
        s_loc = 0; s_act = 0;

        // Abort a SLEEP after one tick at most.
        loc = 0; act = 0; repeat (2) sync();
        d0 = done_cnt; e0 = int'(energy);
        loc = 1; act = 2;
        repeat (5) sync();
        tr = 1;
        repeat (20) sync();
        check("abort_no_pulse", done_cnt, d0);
        check("abort_energy_bounded", int'(int'(energy) <= e0 + BOOST && int'(energy) >= e0 - 1), 1);
        check_main("abort");
        tr = 0; loc = 0; act = 0;

        tl = '{4'd1, 4'd1, 4'd3, 4'd1, 4'd0, 4'd3};
        ta = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd0, 4'd1};
        tt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int s = 0; s < 40; s++) begin
            k = int'($urandom_range(0, 5));
            loc = tl[k]; act = ta[k]; tr = tt[k];
            repeat ($urandom_range(1, 20)) sync();
            check_main("rand");
        end

        // Async reset mid-action.
        loc = 0; act = 0; tr = 0; repeat (2) sync();
        loc = 3; act = 3;
        repeat (4) sync();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_fullness", int'(fullness), 100);
        check("arst_energy", int'(energy), 100);
        check("arst_fun", int'(fun), 100);
        check("arst_done", int'(doneAction), 0);
        check("arst_gameend", int'(gameEnd), 0);
        check("arst_starve_vitals", int'({s_fullness, s_energy, s_fun}), (3 << 14) | (3 << 7) | 3);
        loc = 0; act = 0;
        sync();
        resetn = 1'b1;
        d0 = done_cnt;
        repeat (30) sync();
        check("arst_no_pulse_after", done_cnt, d0);
        check_main("arst_after");
        check_starve("arst_after");

        check("main_queue_drained", q_main.size(), 0);
        check("starve_queue_drained", q_starve.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
